// File: rtl/td4_pkg.sv
// Shared TD4 definitions: opcodes, the LED-chase boot image and the program
// memory loader states. Checksum option: PROG_MEM_CHECKSUM_EN.
package td4_pkg;

  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam int IMAGE_DEPTH = 16;

  // Word 0 sits in the lowest slice.
  localparam logic [IMAGE_DEPTH-1:0][7:0] DEFAULT_IMAGE = {
    {6{8'h00}},
    {OP_JMP,    4'h0},
    {OP_OUT_IM, 4'h1},
    {OP_OUT_IM, 4'h3},
    {OP_OUT_IM, 4'h6},
    {OP_OUT_IM, 4'hC},
    {OP_OUT_IM, 4'h8},
    {OP_OUT_IM, 4'h8},
    {OP_OUT_IM, 4'hC},
    {OP_OUT_IM, 4'h6},
    {OP_OUT_IM, 4'h3}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ERROR
  } prog_mem_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Loader stream and CPU hold bundle between a byte loader and program_memory.
// Checksum option: PROG_MEM_CHECKSUM_EN.
interface program_memory_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output load_start, load_valid, load_data,
    input  load_ready, cpu_hold, load_done, load_error
  );

  modport slave (
    input  load_start, load_valid, load_data,
    output load_ready, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/prog_mem_array.sv
// Program storage: one write port, asynchronous read, reset to boot image.
// Checksum option: PROG_MEM_CHECKSUM_EN.
module prog_mem_array
  import td4_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] img   [DEPTH];

  // Image entries are zero-extended or truncated to the word width.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = '0;
      if (i < IMAGE_DEPTH) begin
        img[i] = DATA_WIDTH'(DEFAULT_IMAGE[i[3:0]]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= img;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_memory.sv
// Writable TD4 program memory with stream loader FSM and CPU hold.
// Checksum option: PROG_MEM_CHECKSUM_EN.
module program_memory
  import td4_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  program_memory_if.slave       ld
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(2**ADDR_WIDTH - 1);

  prog_mem_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic                  done_q, done_d;
  logic                  we;
  logic                  accept;

  assign ld.load_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign accept        = ld.load_valid && ld.load_ready;
  assign ld.load_done  = done_q;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] sum_next;

  assign sum_next      = sum_q + ld.load_data;
  assign ld.cpu_hold   = (state_q != ST_IDLE);
  assign ld.load_error = (state_q == ST_ERROR);
`else
  assign ld.cpu_hold   = ld.load_ready;
  assign ld.load_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ld.load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        // Restart wins over a same-cycle accept; that word is dropped.
        if (ld.load_start) begin
          wptr_d = '0;
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d  = '0;
`endif
        end else if (accept) begin
          we = 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d = sum_next;
`endif
          if (wptr_q == LAST) begin
            wptr_d = '0;
`ifdef PROG_MEM_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
          end
        end
      end
`ifdef PROG_MEM_CHECKSUM_EN
      ST_CHECK: begin
        if (ld.load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          sum_d   = '0;
        end else if (accept) begin
          if (sum_next == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (ld.load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          sum_d   = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      done_q  <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      done_q  <= done_d;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  prog_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wptr_q),
    .wdata (ld.load_data),
    .raddr (address),
    .rdata (data)
  );

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: boot image, loads, restart, reset abort.
// Checksum cases run when PROG_MEM_CHECKSUM_EN is defined.
module tb_program_memory;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data;

  program_memory_if #(.DATA_WIDTH(DW)) ld_if ();

  program_memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data),
    .ld      (ld_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [DW-1:0] golden [DEPTH] = '{
    8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hBC, 8'hB6, 8'hB3,
    8'hB1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  always @(negedge clk) begin
    if (ld_if.load_done === 1'b1) done_cnt++;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = golden[i];
  endtask

  task automatic sweep(string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a);
      exp_q.push_back(model[a]);
      @(negedge clk);
      check($sformatf("%s@%0d", tag, a), 32'(data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic start_load(string tag);
    ld_if.load_start = 1'b1;
    tick();
    ld_if.load_start = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, 32'(ld_if.load_ready), 32'd1);
    check({tag, "_hold"}, 32'(ld_if.cpu_hold), 32'd1);
  endtask

  task automatic send_word(string tag, int idx, logic [DW-1:0] val, bit gap);
    if (gap) begin
      ld_if.load_valid = 1'b0;
      ld_if.load_data  = 8'hEE;
      tick();
      @(negedge clk);
      check({tag, "_gap_hold"}, 32'(ld_if.cpu_hold), 32'd1);
    end
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = val;
    address = AW'(idx);
    model[idx] = val;
    tick();
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = 8'h00;
    @(negedge clk);
    if (idx == 0 || idx == 9) begin
      check($sformatf("%s_wr%0d", tag, idx), 32'(data), 32'(val));
    end
  endtask

  task automatic load_image(string tag, logic [DW-1:0] base, bit gap);
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(tag, i, base + DW'(i), gap);
      sum = sum + base + DW'(i);
    end
`ifdef PROG_MEM_CHECKSUM_EN
    check({tag, "_chk_hold"}, 32'(ld_if.cpu_hold), 32'd1);
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = DW'(0) - sum;
    tick();
    ld_if.load_valid = 1'b0;
    @(negedge clk);
`endif
    check({tag, "_done"}, 32'(ld_if.load_done), 32'd1);
    check({tag, "_hold_off"}, 32'(ld_if.cpu_hold), 32'd0);
    check({tag, "_ready_off"}, 32'(ld_if.load_ready), 32'd0);
    tick();
    @(negedge clk);
    check({tag, "_done_low"}, 32'(ld_if.load_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset            = 1'b1;
    address          = '0;
    ld_if.load_start = 1'b0;
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ld_if.load_ready), 32'd0);
    check("rst_hold", 32'(ld_if.cpu_hold), 32'd0);
    check("rst_done", 32'(ld_if.load_done), 32'd0);
    check("rst_error", 32'(ld_if.load_error), 32'd0);
    sweep("boot");

    // Back-to-back load.
    d0 = done_cnt;
    start_load("b2b");
    load_image("b2b", 8'h10, 1'b0);
    check("b2b_pulses", 32'(done_cnt - d0), 32'd1);
    address = 4'd5;
    @(negedge clk);
    check("b2b_data5", 32'(data), 32'h15);
    sweep("b2b_mem");

    // Valid toggling every other cycle.
    d0 = done_cnt;
    start_load("gap");
    load_image("gap", 8'h30, 1'b1);
    check("gap_pulses", 32'(done_cnt - d0), 32'd1);
    sweep("gap_mem");

    // Restart after 7 words; simultaneous word is dropped.
    d0 = done_cnt;
    start_load("rs");
    for (int i = 0; i < 7; i++) send_word("rs1", i, 8'h55 + DW'(i), 1'b0);
    ld_if.load_start = 1'b1;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 8'hEE;
    tick();
    ld_if.load_start = 1'b0;
    ld_if.load_valid = 1'b0;
    address = 4'd7;
    @(negedge clk);
    check("rs_hold", 32'(ld_if.cpu_hold), 32'd1);
    check("rs_drop7", 32'(data), 32'(model[7]));
    address = 4'd6;
    @(negedge clk);
    check("rs_kept6", 32'(data), 32'h5B);
    load_image("rs", 8'hA0, 1'b0);
    check("rs_pulses", 32'(done_cnt - d0), 32'd1);
    address = 4'd3;
    @(negedge clk);
    check("rs_data3", 32'(data), 32'hA3);

    // Reset aborts a load and restores the boot image.
    start_load("ab");
    for (int i = 0; i < 9; i++) send_word("ab", i, 8'h70 + DW'(i), 1'b0);
    reset = 1'b1;
    address = 4'd0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ab_hold", 32'(ld_if.cpu_hold), 32'd0);
    check("ab_ready", 32'(ld_if.load_ready), 32'd0);
    check("ab_data0", 32'(data), 32'hB3);
    model_reset();
    sweep("ab_mem");

    // Stray valid in IDLE is ignored.
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 8'h99;
    tick();
    ld_if.load_valid = 1'b0;
    address = 4'd0;
    @(negedge clk);
    check("idle_ignore", 32'(data), 32'hB3);
    check("idle_hold", 32'(ld_if.cpu_hold), 32'd0);

`ifdef PROG_MEM_CHECKSUM_EN
    // All-zero image, good checksum.
    start_load("cz");
    load_image("cz", 8'h00, 1'b0);
    // All-zero image, bad checksum.
    start_load("ce");
    for (int i = 0; i < DEPTH; i++) send_word("ce", i, 8'h00, 1'b0);
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 8'h01;
    tick();
    ld_if.load_valid = 1'b0;
    @(negedge clk);
    check("ce_error", 32'(ld_if.load_error), 32'd1);
    check("ce_hold", 32'(ld_if.cpu_hold), 32'd1);
    check("ce_ready", 32'(ld_if.load_ready), 32'd0);
    check("ce_done", 32'(ld_if.load_done), 32'd0);
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    check("ce_error_held", 32'(ld_if.load_error), 32'd1);
    check("ce_hold_held", 32'(ld_if.cpu_hold), 32'd1);
    start_load("cr");
    check("cr_error_clr", 32'(ld_if.load_error), 32'd0);
    load_image("cr", 8'h20, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
